// File: rtl/pb_debouncer.sv
// ---------------------------------------------------------------------------
// pb_debouncer
//   Turns one raw, bouncy push-button pin into a clean debounced level. The
//   pin goes through a 2-FF synchronizer. A level change is passed on only
//   after STABLE_CYCLES consecutive synchronized samples of the new level.
//   Every qualification that is abandoned early is counted in a saturating
//   diagnostic counter.
//
// Ports
//   clk         system clock, every flop samples on posedge
//   rst_n       asynchronous active-low reset
//   pb_raw      raw button pin, asynchronous to clk
//   bounce_clr  one-cycle synchronous clear of bounce_cnt
//   pb_db       debounced level (registered)
//   busy        high while a level change is being qualified (registered)
//   bounce_cnt  number of aborted qualifications, saturating (registered)
//
// States
//   state  | meaning
//   S_LOW  | debounced level 0, input agrees
//   S_RISE | debounced level 0, counting consecutive high samples
//   S_HIGH | debounced level 1, input agrees
//   S_FALL | debounced level 1, counting consecutive low samples
// ---------------------------------------------------------------------------
module pb_debouncer #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter int BNC_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pb_raw,
    input  logic             bounce_clr,
    output logic             pb_db,
    output logic             busy,
    output logic [BNC_W-1:0] bounce_cnt
);

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        S_RISE = 2'd1,
        S_HIGH = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_s1;
    logic               r_s;
    logic               r_pb_db;
    logic               r_busy;
    logic [BNC_W-1:0]   r_bnc;
    logic               w_abort;

    // The FSM only ever looks at r_s, never at the raw pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s  <= 1'b0;
        end else begin
            r_s1 <= pb_raw;
            r_s  <= r_s1;
        end
    end

    // A qualification is abandoned when the sample returns to the current level.
    assign w_abort = ((r_state == S_RISE) && !r_s) ||
                     ((r_state == S_FALL) &&  r_s);

    // pb_db and busy are updated together with the state, so they are
    // registered decodes of it and never lag behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_pb_db <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_LOW: begin
                    if (r_s) begin
                        r_state <= S_RISE;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                S_RISE: begin
                    if (!r_s) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        r_pb_db <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!r_s) begin
                        r_state <= S_FALL;
                        r_cnt   <= CNT_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                S_FALL: begin
                    if (r_s) begin
                        r_state <= S_HIGH;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_LOW;
                        r_cnt   <= '0;
                        r_pb_db <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_LOW;
                    r_cnt   <= '0;
                    r_pb_db <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Clear wins over a simultaneous abort; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bnc <= '0;
        end else if (bounce_clr) begin
            r_bnc <= '0;
        end else if (w_abort && (r_bnc != {BNC_W{1'b1}})) begin
            r_bnc <= r_bnc + BNC_W'(1);
        end
    end

    assign pb_db      = r_pb_db;
    assign busy       = r_busy;
    assign bounce_cnt = r_bnc;

endmodule

// File: tb/tb_pb_debouncer.sv
module tb_pb_debouncer;

    localparam int STABLE = 4;
    localparam int BNC_W  = 8;
    localparam int BNC_MAX = (1 << BNC_W) - 1;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b1;
    logic             pb_raw     = 1'b0;
    logic             bounce_clr = 1'b0;
    logic             pb_db;
    logic             busy;
    logic [BNC_W-1:0] bounce_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the raw pin seen two edges late, and the length of
    // the current run of samples that disagree with the debounced level.
    bit m_pipe[$];
    bit m_db;
    int m_run;
    int m_bnc;

    always #5 clk = ~clk;

    pb_debouncer #(
        .STABLE_CYCLES(STABLE),
        .BNC_W        (BNC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pb_raw    (pb_raw),
        .bounce_clr(bounce_clr),
        .pb_db     (pb_db),
        .busy      (busy),
        .bounce_cnt(bounce_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pipe.delete();
        m_pipe.push_back(1'b0);
        m_pipe.push_back(1'b0);
        m_db  = 1'b0;
        m_run = 0;
        m_bnc = 0;
    endtask

    task automatic model_edge(input bit raw, input bit clr);
        bit s;
        bit abort;
        s     = m_pipe[0];
        void'(m_pipe.pop_front());
        m_pipe.push_back(raw);
        abort = 1'b0;
        if (s != m_db) begin
            m_run++;
            if (m_run == STABLE) begin
                m_db  = s;
                m_run = 0;
            end
        end else begin
            if (m_run > 0) abort = 1'b1;
            m_run = 0;
        end
        if (clr) m_bnc = 0;
        else if (abort && m_bnc < BNC_MAX) m_bnc++;
    endtask

    task automatic step(input bit raw, input bit clr, input string tag);
        pb_raw     = raw;
        bounce_clr = clr;
        @(posedge clk);
        model_edge(raw, clr);
        #1;
        chk({tag, ".pb_db"},      pb_db,      m_db);
        chk({tag, ".busy"},       busy,       (m_run > 0));
        chk({tag, ".bounce_cnt"}, bounce_cnt, m_bnc);
        bounce_clr = 1'b0;
    endtask

    // Called at posedge+1 or earlier; asserts reset between edges.
    task automatic do_reset(input string tag, input int hold_edges);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".rst_pb_db"}, pb_db,      0);
        chk({tag, ".rst_busy"},  busy,       0);
        chk({tag, ".rst_bnc"},   bounce_cnt, 0);
        for (int i = 0; i < hold_edges; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_pb_db"}, pb_db, 0);
            chk({tag, ".hold_busy"},  busy,  0);
        end
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int rise_idx;
        bit lvl;
        int len;
        bit clr;

        model_reset();

        // Reset with the button held: nothing may leak through.
        pb_raw = 1'b1;
        #1;
        do_reset("reset", 3);
        rise_idx = -1;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, "reset_qual");
            if (pb_db === 1'b1 && rise_idx < 0) rise_idx = i;
        end
        chk("reset_rise_edge", rise_idx, STABLE + 1);

        // Clean release, then clean press with explicit latency checks.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "release");
        chk("release_pb_db", pb_db, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, "press");
            chk("press_busy_at", busy, (i >= 2 && i <= STABLE));
            chk("press_db_at",   pb_db, (i >= STABLE + 1));
        end

        // Back low, then a 3-cycle glitch.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "settle_low");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "glitch_hi");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "glitch_lo");
        chk("glitch_pb_db", pb_db, 0);
        chk("glitch_busy",  busy,  0);
        chk("glitch_bnc",   bounce_cnt, 1);

        // Bouncy release from a settled high level.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "settle_high");
        chk("bouncy_start_db", pb_db, 1);
        begin
            bit pat [12] = '{0,1,0,0,1,0,0,0,0,0,0,0};
            for (int i = 0; i < 12; i++) begin
                step(pat[i], 1'b0, "bouncy");
                // Last low run starts at pattern index 5, seen two edges late.
                chk("bouncy_db_at", pb_db, (i < 10));
            end
        end
        chk("bouncy_bnc", bounce_cnt, 3);

        // Saturation, then clear in the same cycle as an abort.
        for (int g = 0; g < 300; g++) begin
            step(1'b1, 1'b0, "sat");
            step(1'b1, 1'b0, "sat");
            step(1'b0, 1'b0, "sat");
            step(1'b0, 1'b0, "sat");
            step(1'b0, 1'b0, "sat");
        end
        chk("sat_bnc", bounce_cnt, BNC_MAX);
        step(1'b1, 1'b0, "clr_prio");
        step(1'b1, 1'b0, "clr_prio");
        step(1'b0, 1'b0, "clr_prio");
        step(1'b0, 1'b0, "clr_prio");
        step(1'b0, 1'b1, "clr_prio");
        chk("clr_prio_bnc", bounce_cnt, 0);
        step(1'b0, 1'b0, "clr_after");

        // Randomized runs of random length with occasional clears.
        for (int r = 0; r < 120; r++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                clr = ($urandom_range(0, 15) == 0);
                step(lvl, clr, "random");
            end
        end

        // Reset during a rising qualification, button still held.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "pre_mid");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "mid_rise");
        chk("mid_busy_before", busy, 1);
        do_reset("mid_reset", 0);
        rise_idx = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, "mid_requal");
            if (pb_db === 1'b1 && rise_idx < 0) rise_idx = i;
        end
        chk("mid_rise_edge", rise_idx, STABLE + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
